// File: rtl/spi_ram_ctrl_v2.sv
// SPI-slave command block driving a single-port RAM: address set, write, read with valid/ready return path.
// Define SPI_RAM_PARITY_EN to store an even-parity bit per word and report parity_err on reads.
module spi_ram_ctrl_v2 #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              cmd_drop
`ifdef SPI_RAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam logic [1:0] OP_SET_WR = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RD = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] LAST  = DEPTH - 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]        opcode;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] payload_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr_inc;
    logic [ADDR_W-1:0] rd_addr_inc;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              accept;
    logic              drop_evt;
    logic              mem_we;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Addresses at or beyond the last word (including out-of-range ones) wrap to zero.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if ({1'b0, a} >= LAST)
            return '0;
        else
            return a + 1'b1;
    endfunction

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH);
    endfunction

    assign opcode  = din[DATA_W+1:DATA_W];
    assign payload = din[DATA_W-1:0];

    generate
        if (ADDR_W <= DATA_W) begin : g_addr_from_payload
            assign payload_addr = payload[ADDR_W-1:0];
        end else begin : g_addr_zero_ext
            assign payload_addr = {{(ADDR_W-DATA_W){1'b0}}, payload};
        end
    endgenerate

    assign wr_in_range = addr_ok(wr_addr);
    assign rd_in_range = addr_ok(rd_addr);
    assign wr_idx      = IDX_W'(wr_addr);
    assign rd_idx      = IDX_W'(rd_addr);
    assign wr_addr_inc = (AUTO_INC != 0) ? next_addr(wr_addr) : wr_addr;
    assign rd_addr_inc = (AUTO_INC != 0) ? next_addr(rd_addr) : rd_addr;
    assign rd_word     = rd_in_range ? mem[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && (opcode == OP_READ)) state_next = HOLD;
            HOLD: if (tx_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (state == HOLD);
        rx_ready = ~tx_valid;
        accept   = rx_valid && rx_ready;
        drop_evt = rx_valid && !rx_ready;
        mem_we   = accept && (opcode == OP_WRITE) && wr_in_range;
    end

    // Storage is never reset; a command coinciding with reset is ignored.
    always_ff @(posedge clk) begin
        if (!rst && mem_we)
            mem[wr_idx] <= payload;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            cmd_drop <= 1'b0;
        end else begin
            if (drop_evt)
                cmd_drop <= 1'b1;
            if (accept) begin
                case (opcode)
                    OP_SET_WR: wr_addr <= payload_addr;
                    OP_WRITE:  wr_addr <= wr_addr_inc;
                    OP_SET_RD: rd_addr <= payload_addr;
                    OP_READ: begin
                        dout    <= rd_word;
                        rd_addr <= rd_addr_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_RAM_PARITY_EN
    logic mem_par [MEM_DEPTH];
    logic rd_par_err;

    assign rd_par_err = rd_in_range ? ((^mem[rd_idx]) != mem_par[rd_idx]) : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst && mem_we)
            mem_par[wr_idx] <= ^payload;
    end

    always_ff @(posedge clk) begin
        if (rst)
            parity_err <= 1'b0;
        else if (accept && (opcode == OP_READ))
            parity_err <= rd_par_err;
    end
`endif

endmodule

// File: tb/tb_spi_ram_ctrl_v2.sv
// Directed bench for spi_ram_ctrl_v2 (MEM_DEPTH=200 so both wrap and out-of-range paths are reachable).
// Per-cycle vectors with hand-computed expectations; parity checks run when SPI_RAM_PARITY_EN is defined.
module tb_spi_ram_ctrl_v2;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int MEM_DEPTH = 200;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              tx_ready;
    logic              cmd_drop;
`ifdef SPI_RAM_PARITY_EN
    logic              parity_err;
`endif

    always #5 clk = ~clk;

    spi_ram_ctrl_v2 #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_DEPTH(MEM_DEPTH),
        .AUTO_INC (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .dout      (dout),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .cmd_drop  (cmd_drop)
`ifdef SPI_RAM_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    typedef struct {
        logic       rst;
        logic       rx_valid;
        logic [1:0] op;
        logic [7:0] pay;
        logic       tx_ready;
        logic       exp_txv;
        logic [7:0] exp_dout;
        logic       exp_drop;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic void add(input logic r, input logic v, input logic [1:0] op,
                                input logic [7:0] pay, input logic tr, input logic etv,
                                input logic [7:0] ed, input logic edrop);
        vec_t x;
        x.rst = r; x.rx_valid = v; x.op = op; x.pay = pay; x.tx_ready = tr;
        x.exp_txv = etv; x.exp_dout = ed; x.exp_drop = edrop;
        vecs.push_back(x);
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the edge, outputs are sampled at the same point.
    task automatic apply_stimulus(input logic r, input logic v, input logic [1:0] op,
                                  input logic [7:0] pay, input logic tr);
        rst      = r;
        rx_valid = v;
        din      = {op, pay};
        tx_ready = tr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; din = '0; tx_ready = 1'b0;
        #2;

        // Write 0xA5 at 0x10, read it back holding for three cycles.
        add(1,0,2'b00,8'h00,0, 0,8'h00,0);
        add(0,1,2'b00,8'h10,0, 0,8'h00,0);
        add(0,1,2'b01,8'hA5,0, 0,8'h00,0);
        add(0,1,2'b10,8'h10,0, 0,8'h00,0);
        add(0,1,2'b11,8'h00,0, 1,8'hA5,0);
        add(0,0,2'b00,8'h00,0, 1,8'hA5,0);
        add(0,0,2'b00,8'h00,0, 1,8'hA5,0);
        add(0,0,2'b00,8'h00,1, 0,8'hA5,0);
        // Auto-increment across the wrap at MEM_DEPTH-1 = 0xC7.
        add(0,1,2'b00,8'hC6,1, 0,8'hA5,0);
        add(0,1,2'b01,8'h11,1, 0,8'hA5,0);
        add(0,1,2'b01,8'h22,1, 0,8'hA5,0);
        add(0,1,2'b01,8'h33,1, 0,8'hA5,0);
        add(0,1,2'b10,8'hC6,1, 0,8'hA5,0);
        add(0,1,2'b11,8'h00,1, 1,8'h11,0);
        add(0,0,2'b00,8'h00,1, 0,8'h11,0);
        add(0,1,2'b11,8'h00,1, 1,8'h22,0);
        add(0,0,2'b00,8'h00,1, 0,8'h22,0);
        add(0,1,2'b11,8'h00,1, 1,8'h33,0);
        add(0,0,2'b00,8'h00,1, 0,8'h33,0);
        // Commands during HOLD are dropped, including a read in the handshake cycle.
        add(0,1,2'b00,8'h20,0, 0,8'h33,0);
        add(0,1,2'b01,8'h5A,0, 0,8'h33,0);
        add(0,1,2'b10,8'h20,0, 0,8'h33,0);
        add(0,1,2'b11,8'h00,0, 1,8'h5A,0);
        add(0,1,2'b00,8'h40,0, 1,8'h5A,1);
        add(0,1,2'b11,8'h00,1, 0,8'h5A,1);
        add(0,1,2'b01,8'h66,0, 0,8'h5A,1);
        add(0,1,2'b10,8'h21,0, 0,8'h5A,1);
        add(0,1,2'b11,8'h00,1, 1,8'h66,1);
        add(0,0,2'b00,8'h00,1, 0,8'h66,1);
        // Out-of-range address 0xC8: write discarded, read gives 0, both then wrap to 0.
        add(0,1,2'b00,8'hC8,0, 0,8'h66,1);
        add(0,1,2'b01,8'h77,0, 0,8'h66,1);
        add(0,1,2'b10,8'hC8,0, 0,8'h66,1);
        add(0,1,2'b11,8'h00,1, 1,8'h00,1);
        add(0,0,2'b00,8'h00,1, 0,8'h00,1);
        add(0,1,2'b11,8'h00,1, 1,8'h33,1);
        add(0,0,2'b00,8'h00,1, 0,8'h33,1);
        // Reset during HOLD with a write presented; memory survives, addresses return to 0.
        add(0,1,2'b10,8'h20,0, 0,8'h33,1);
        add(0,1,2'b11,8'h00,0, 1,8'h5A,1);
        add(1,1,2'b01,8'hEE,0, 0,8'h00,0);
        add(0,1,2'b11,8'h00,1, 1,8'h33,0);
        add(0,0,2'b00,8'h00,1, 0,8'h33,0);
        add(0,1,2'b01,8'h44,1, 0,8'h33,0);
        add(0,1,2'b10,8'h00,1, 0,8'h33,0);
        add(0,1,2'b11,8'h00,1, 1,8'h44,0);
        add(0,0,2'b00,8'h00,1, 0,8'h44,0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].rx_valid, vecs[i].op, vecs[i].pay, vecs[i].tx_ready);
            check_output($sformatf("v%0d tx_valid", i), 16'(tx_valid), 16'(vecs[i].exp_txv));
            check_output($sformatf("v%0d rx_ready", i), 16'(rx_ready), 16'(!vecs[i].exp_txv));
            check_output($sformatf("v%0d dout", i),     16'(dout),     16'(vecs[i].exp_dout));
            check_output($sformatf("v%0d cmd_drop", i), 16'(cmd_drop), 16'(vecs[i].exp_drop));
        end

`ifdef SPI_RAM_PARITY_EN
        // Corrupt the stored parity of address 3 and read it and its clean neighbour.
        apply_stimulus(0,1,2'b00,8'h03,1);
        apply_stimulus(0,1,2'b01,8'h07,1);
        apply_stimulus(0,1,2'b01,8'h07,1);
        dut.mem_par[3] = ~dut.mem_par[3];
        apply_stimulus(0,1,2'b10,8'h03,1);
        apply_stimulus(0,1,2'b11,8'h00,1);
        check_output("par flipped dout", 16'(dout), 16'h07);
        check_output("par flipped err", 16'(parity_err), 16'h1);
        apply_stimulus(0,0,2'b00,8'h00,1);
        check_output("par err held", 16'(parity_err), 16'h1);
        apply_stimulus(0,1,2'b11,8'h00,1);
        check_output("par clean dout", 16'(dout), 16'h07);
        check_output("par clean err", 16'(parity_err), 16'h0);
        apply_stimulus(0,0,2'b00,8'h00,1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
